mc_controller: RTL and testbench

MC_CONTROLLER -- requirements
Module: mc_controller

---
 rtl/mc_controller_if.sv | 41 ++++
 rtl/mc_controller.sv | 194 +++++++++++++++++++
 tb/tb_mc_controller.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mc_controller_if.sv
// Handshake/bus bundle between the multicycle datapath and its controller.
// The slave modport is the controller side; the master modport is the datapath side.
// CNT_WIDTH sets the width of the retired-instruction counter.
interface mc_controller_if #(
  parameter int CNT_WIDTH = 32
);
  logic [5:0]           op;
  logic                 zero;
  logic                 mem_ready;
  logic                 mem_req;
  logic                 iord;
  logic                 irwrite;
  logic                 pcwrite;
  logic                 branch;
  logic                 pcen;
  logic                 alusrca;
  logic                 regdst;
  logic                 memtoreg;
  logic                 regwrite;
  logic                 memwrite;
  logic [1:0]           alusrcb;
  logic [1:0]           pcsrc;
  logic [1:0]           aluop;
  logic [3:0]           state;
  logic                 illegal;
  logic [CNT_WIDTH-1:0] instr_count;

  modport slave (
    input  op, zero, mem_ready,
    output mem_req, iord, irwrite, pcwrite, branch, pcen, alusrca, regdst,
           memtoreg, regwrite, memwrite, alusrcb, pcsrc, aluop,
           state, illegal, instr_count
  );

  modport master (
    output op, zero, mem_ready,
    input  mem_req, iord, irwrite, pcwrite, branch, pcen, alusrca, regdst,
           memtoreg, regwrite, memwrite, alusrcb, pcsrc, aluop,
           state, illegal, instr_count
  );
endinterface

// File: rtl/mc_controller.sv
// Multicycle MIPS-style controller FSM with retired-instruction counter; optional bne via MC_BNE_EN.
// Latency: beq/j 3, R-type/addi/sw 4, lw 5 cycles; outputs are combinational from state.
// Backpressure: FETCH, MEMRD and MEMWR hold while mem_ready=0, keeping their strobes asserted.
module mc_controller #(
  parameter int CNT_WIDTH = 32
) (
  input  logic            clk,
  input  logic            reset,
  mc_controller_if.slave  bus
);

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    EXECUTE = 4'd6,
    ALUWB   = 4'd7,
    BRANCH  = 4'd8,
    ADDIEX  = 4'd9,
    ADDIWB  = 4'd10,
    JUMP    = 4'd11
  } state_t;

  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
`ifdef MC_BNE_EN
  localparam logic [5:0] OP_BNE   = 6'b000101;
`endif

  state_t               state_q, state_d;
  logic                 illegal_q, illegal_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;
  logic                 retire;
  logic                 take;
  logic                 pcwrite_c, branch_c;
`ifdef MC_BNE_EN
  logic                 bne_q, bne_d;
`endif

  // Next state, one-cycle illegal flag and branch-sense capture.
  always_comb begin
    state_d   = state_q;
    illegal_d = 1'b0;
`ifdef MC_BNE_EN
    bne_d     = bne_q;
`endif
    case (state_q)
      FETCH:   if (bus.mem_ready) state_d = DECODE;
      DECODE: begin
        case (bus.op)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_RTYPE:     state_d = EXECUTE;
          OP_BEQ: begin
            state_d = BRANCH;
`ifdef MC_BNE_EN
            bne_d   = 1'b0;
`endif
          end
`ifdef MC_BNE_EN
          OP_BNE: begin
            state_d = BRANCH;
            bne_d   = 1'b1;
          end
`endif
          OP_ADDI:      state_d = ADDIEX;
          OP_J:         state_d = JUMP;
          default: begin
            state_d   = FETCH;
            illegal_d = 1'b1;
          end
        endcase
      end
      MEMADR:  state_d = (bus.op == OP_LW) ? MEMRD : MEMWR;
      MEMRD:   if (bus.mem_ready) state_d = MEMWB;
      MEMWR:   if (bus.mem_ready) state_d = FETCH;
      EXECUTE: state_d = ALUWB;
      ADDIEX:  state_d = ADDIWB;
      default: state_d = FETCH;
    endcase
  end

  // Count instructions on the edge that leaves their final state.
  always_comb begin
    retire  = (state_q == MEMWB) || (state_q == ALUWB) || (state_q == ADDIWB) ||
              (state_q == BRANCH) || (state_q == JUMP) ||
              ((state_q == MEMWR) && bus.mem_ready);
    count_d = retire ? (count_q + CNT_WIDTH'(1)) : count_q;
  end

  // State, counter and flag registers; reset wins over any wait in progress.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= FETCH;
      illegal_q <= 1'b0;
      count_q   <= '0;
`ifdef MC_BNE_EN
      bne_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
      count_q   <= count_d;
`ifdef MC_BNE_EN
      bne_q     <= bne_d;
`endif
    end
  end

  // Datapath strobes decoded from the current state; anything not listed stays 0.
  always_comb begin
    bus.mem_req  = 1'b0;
    bus.iord     = 1'b0;
    bus.irwrite  = 1'b0;
    pcwrite_c    = 1'b0;
    branch_c     = 1'b0;
    bus.alusrca  = 1'b0;
    bus.regdst   = 1'b0;
    bus.memtoreg = 1'b0;
    bus.regwrite = 1'b0;
    bus.memwrite = 1'b0;
    bus.alusrcb  = 2'b00;
    bus.pcsrc    = 2'b00;
    bus.aluop    = 2'b00;
    case (state_q)
      FETCH: begin
        bus.mem_req = 1'b1;
        bus.alusrcb = 2'b01;
        bus.irwrite = bus.mem_ready;
        pcwrite_c   = bus.mem_ready;
      end
      DECODE:  bus.alusrcb = 2'b11;
      MEMADR, ADDIEX: begin
        bus.alusrca = 1'b1;
        bus.alusrcb = 2'b10;
      end
      MEMRD: begin
        bus.iord    = 1'b1;
        bus.mem_req = 1'b1;
      end
      MEMWR: begin
        bus.iord     = 1'b1;
        bus.mem_req  = 1'b1;
        bus.memwrite = 1'b1;
      end
      MEMWB: begin
        bus.memtoreg = 1'b1;
        bus.regwrite = 1'b1;
      end
      ALUWB: begin
        bus.regdst   = 1'b1;
        bus.regwrite = 1'b1;
      end
      ADDIWB:  bus.regwrite = 1'b1;
      EXECUTE: begin
        bus.alusrca = 1'b1;
        bus.aluop   = 2'b10;
      end
      BRANCH: begin
        bus.alusrca = 1'b1;
        bus.aluop   = 2'b01;
        bus.pcsrc   = 2'b01;
        branch_c    = 1'b1;
      end
      JUMP: begin
        bus.pcsrc = 2'b10;
        pcwrite_c = 1'b1;
      end
      default: ;
    endcase
  end

  // PC enable combines unconditional writes with a taken branch.
  always_comb begin
`ifdef MC_BNE_EN
    take = bus.zero ^ bne_q;
`else
    take = bus.zero;
`endif
    bus.pcwrite     = pcwrite_c;
    bus.branch      = branch_c;
    bus.pcen        = pcwrite_c | (branch_c & take);
    bus.state       = state_q;
    bus.illegal     = illegal_q;
    bus.instr_count = count_q;
  end

endmodule

// File: tb/tb_mc_controller.sv
// Bench for mc_controller: reset checks, directed multi-cycle sequences, a per-opcode
// vector table, and a randomized run against an instruction-level path model.
module tb_mc_controller;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mc_controller_if #(.CNT_WIDTH(CW)) bus();
  mc_controller #(.CNT_WIDTH(CW)) dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct {
    logic [5:0] op;
    logic       zero;
    int         cycles;
    int         inc;
    logic       ill;
    logic       pcen;
  } vec_t;

  vec_t       vecs[9];
  logic [5:0] rops[8];
  int         n_chk  = 0;
  int         n_pass = 0;

  // model state for the randomized run
  int         path[$];
  bit         path_ill;
  bit         path_bne;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  function automatic logic [16:0] act_out();
    return {bus.mem_req, bus.iord, bus.irwrite, bus.pcwrite, bus.branch, bus.pcen,
            bus.alusrca, bus.regdst, bus.memtoreg, bus.regwrite, bus.memwrite,
            bus.alusrcb, bus.pcsrc, bus.aluop};
  endfunction

  // Output table per state, straight from the strobe list for each state.
  function automatic logic [16:0] spec_out(input int st, input logic mr, input logic z, input bit bne);
    logic mreq, iord, irw, pcw, br, pcen, asa, rdst, m2r, rw, mw;
    logic [1:0] asb, psrc, aop;
    {mreq, iord, irw, pcw, br, asa, rdst, m2r, rw, mw} = '0;
    asb = 2'b00; psrc = 2'b00; aop = 2'b00;
    case (st)
      0:  begin mreq = 1; asb = 2'b01; irw = mr; pcw = mr; end
      1:  asb = 2'b11;
      2, 9: begin asa = 1; asb = 2'b10; end
      3:  begin iord = 1; mreq = 1; end
      4:  begin m2r = 1; rw = 1; end
      5:  begin iord = 1; mreq = 1; mw = 1; end
      6:  begin asa = 1; aop = 2'b10; end
      7:  begin rdst = 1; rw = 1; end
      8:  begin asa = 1; aop = 2'b01; psrc = 2'b01; br = 1; end
      10: rw = 1;
      11: begin psrc = 2'b10; pcw = 1; end
      default: ;
    endcase
    pcen = pcw | (br & (z ^ bne));
    return {mreq, iord, irw, pcw, br, pcen, asa, rdst, m2r, rw, mw, asb, psrc, aop};
  endfunction

  // Sequence of states an instruction visits, FETCH first.
  task automatic set_path(input logic [5:0] o);
    path_ill = 0;
    path_bne = 0;
    case (o)
      6'b100011: path = {0, 1, 2, 3, 4};
      6'b101011: path = {0, 1, 2, 5};
      6'b000000: path = {0, 1, 6, 7};
      6'b000100: path = {0, 1, 8};
      6'b001000: path = {0, 1, 9, 10};
      6'b000010: path = {0, 1, 11};
`ifdef MC_BNE_EN
      6'b000101: begin path = {0, 1, 8}; path_bne = 1; end
`endif
      default: begin path = {0, 1}; path_ill = 1; end
    endcase
  endtask

  // Runs one instruction from FETCH with mem_ready=1; ends at the next FETCH.
  task automatic run_row(input vec_t v, input string nm);
    int cyc;
    int st;
    logic pc_or;
    logic [CW-1:0] c0;
    logic [CW-1:0] d;
    bus.op = v.op;
    bus.zero = v.zero;
    bus.mem_ready = 1'b1;
    #1;
    chk({nm, "_start"}, bus.state, 0);
    c0 = bus.instr_count;
    cyc = 1;
    pc_or = 1'b0;
    do begin
      step();
      st = int'(bus.state);
      if (st != 0) begin
        cyc++;
        pc_or |= bus.pcen;
      end
    end while (st != 0 && cyc < 20);
    d = bus.instr_count - c0;
    chk({nm, "_cycles"}, cyc, v.cycles);
    chk({nm, "_inc"}, d, v.inc);
    chk({nm, "_illegal"}, bus.illegal, v.ill);
    chk({nm, "_pcen"}, pc_or, v.pcen);
  endtask

  int seq26[5];
  int seq27[8];
  logic mr27[8];
  int m2r_cnt;
  int idx;
  int ecount;
  bit ill_next;
  logic [5:0] cur_op;
  logic mr, z;
  int est;

  initial begin
    vecs[0] = '{6'b000000, 1'b0, 4, 1, 1'b0, 1'b0};
    vecs[1] = '{6'b100011, 1'b0, 5, 1, 1'b0, 1'b0};
    vecs[2] = '{6'b101011, 1'b0, 4, 1, 1'b0, 1'b0};
    vecs[3] = '{6'b000100, 1'b1, 3, 1, 1'b0, 1'b1};
    vecs[4] = '{6'b000100, 1'b0, 3, 1, 1'b0, 1'b0};
    vecs[5] = '{6'b001000, 1'b0, 4, 1, 1'b0, 1'b0};
    vecs[6] = '{6'b000010, 1'b0, 3, 1, 1'b0, 1'b1};
    vecs[7] = '{6'b111111, 1'b0, 2, 0, 1'b1, 1'b0};
`ifdef MC_BNE_EN
    vecs[8] = '{6'b000101, 1'b0, 3, 1, 1'b0, 1'b1};
`else
    vecs[8] = '{6'b000101, 1'b0, 2, 0, 1'b1, 1'b0};
`endif
    rops = '{6'b100011, 6'b101011, 6'b000000, 6'b000100,
             6'b001000, 6'b000010, 6'b000101, 6'b111111};
    seq26 = '{0, 1, 6, 7, 0};
    seq27 = '{0, 1, 2, 3, 3, 3, 4, 0};
    mr27  = '{1, 1, 1, 0, 0, 1, 1, 1};

    bus.op = 6'b000000;
    bus.zero = 1'b0;
    bus.mem_ready = 1'b0;
    reset = 1'b0;
    do_reset();

    // reset state, then a stalled fetch must not write anything
    chk("rst_state", bus.state, 0);
    chk("rst_count", bus.instr_count, 0);
    chk("rst_illegal", bus.illegal, 0);
    for (int i = 0; i < 2; i++) begin
      chk("stall_state", bus.state, 0);
      chk("stall_out", act_out(), spec_out(0, 1'b0, 1'b0, 0));
      chk("stall_writes", {bus.irwrite, bus.pcwrite, bus.regwrite, bus.memwrite, bus.pcen}, 0);
      step();
    end

    // R-type walk: regwrite/regdst only in ALUWB
    bus.op = 6'b000000;
    bus.mem_ready = 1'b1;
    #1;
    for (int i = 0; i < 5; i++) begin
      chk("rtype_state", bus.state, seq26[i]);
      chk("rtype_regwrite", bus.regwrite, seq26[i] == 7);
      chk("rtype_regdst", bus.regdst, seq26[i] == 7);
      if (i < 4) step();
    end
    chk("rtype_count", bus.instr_count, 1);

    for (int i = 0; i < 9; i++) run_row(vecs[i], $sformatf("vec%0d", i));

    // lw with two memory wait cycles in MEMRD
    bus.op = 6'b100011;
    m2r_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      bus.mem_ready = mr27[i];
      #1;
      chk("lwwait_state", bus.state, seq27[i]);
      if (bus.memtoreg) m2r_cnt++;
      if (i < 7) step();
    end
    chk("lwwait_memtoreg", m2r_cnt, 1);

    // reset while MEMWR is waiting on memory
    bus.op = 6'b101011;
    bus.mem_ready = 1'b1;
    step();
    step();
    step();
    bus.mem_ready = 1'b0;
    #1;
    chk("swwait_state", bus.state, 5);
    chk("swwait_memwrite", bus.memwrite, 1);
    step();
    chk("swhold_state", bus.state, 5);
    do_reset();
    chk("swrst_state", bus.state, 0);
    chk("swrst_memwrite", bus.memwrite, 0);
    chk("swrst_count", bus.instr_count, 0);

    // counter wrap with 16 jumps
    for (int k = 0; k < 16; k++) run_row(vecs[6], "jwrap");
    chk("jwrap_count", bus.instr_count, 0);

    // randomized run against the path model
    do_reset();
    idx = 0;
    ecount = 0;
    ill_next = 0;
    cur_op = rops[$urandom_range(0, 7)];
    set_path(cur_op);
    for (int cyc = 0; cyc < 800; cyc++) begin
      bus.op = cur_op;
      mr = ($urandom_range(0, 3) != 0);
      z = 1'($urandom);
      bus.mem_ready = mr;
      bus.zero = z;
      #1;
      est = path[idx];
      chk("rnd_state", bus.state, est);
      chk("rnd_out", act_out(), spec_out(est, mr, z, path_bne));
      chk("rnd_illegal", bus.illegal, ill_next);
      chk("rnd_count", bus.instr_count, ecount);
      ill_next = 0;
      if (!((est == 0 || est == 3 || est == 5) && !mr)) begin
        idx++;
        if (idx == path.size()) begin
          if (path_ill) ill_next = 1;
          else ecount = (ecount + 1) % (1 << CW);
          idx = 0;
          cur_op = rops[$urandom_range(0, 7)];
          set_path(cur_op);
        end
      end
      @(negedge clk);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
